// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyzer serial front end: UART framing,
// command word layout and state encodings.
package la_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned FRAME_BITS = 10;

  // Command word fields: {opcode, register address, data}
  localparam int unsigned OPC_MSB  = 15;
  localparam int unsigned OPC_LSB  = 14;
  localparam int unsigned ADDR_MSB = 13;
  localparam int unsigned ADDR_LSB = 8;
  localparam int unsigned DATA_MSB = 7;
  localparam int unsigned DATA_LSB = 0;

  typedef enum logic [1:0] {AsmWaitHi, AsmWaitLo, AsmHold} asm_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic {TxIdle, TxXmit} tx_state_e;

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling, one-cycle byte_rdy or
// frm_err pulse per frame.
module uart_rx
  import la_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       byte_rdy_o,
  output logic       frm_err_o
);

  localparam logic [15:0] BitEnd  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HalfEnd = 16'(BAUD_DIV / 2 - 1);
  localparam logic [2:0]  LastBit = 3'(DATA_BITS - 1);

  rx_state_e   state_q;
  logic        sync1_q, sync2_q, prev_q;
  logic [15:0] cnt_q;
  logic [2:0]  idx_q;
  logic [7:0]  shift_q, data_q;
  logic        byte_rdy_q, frm_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      state_q    <= RxIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      byte_rdy_q <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      sync1_q    <= rx_i;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      byte_rdy_q <= 1'b0;
      frm_err_q  <= 1'b0;
      unique case (state_q)
        RxIdle: begin
          if (prev_q && !sync2_q) begin
            state_q <= RxStart;
            cnt_q   <= '0;
          end
        end
        RxStart: begin
          if (cnt_q == HalfEnd) begin
            // A start bit that is high again at mid-bit was a glitch
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= sync2_q ? RxIdle : RxData;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RxData: begin
          if (cnt_q == BitEnd) begin
            cnt_q   <= '0;
            shift_q <= {sync2_q, shift_q[7:1]};
            if (idx_q == LastBit) state_q <= RxStop;
            else                  idx_q   <= idx_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RxStop: begin
          if (cnt_q == BitEnd) begin
            if (sync2_q) begin
              byte_rdy_q <= 1'b1;
              data_q     <= shift_q;
            end else begin
              frm_err_q <= 1'b1;
            end
            cnt_q   <= '0;
            state_q <= RxIdle;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= RxIdle;
      endcase
    end
  end

  assign data_o     = data_q;
  assign byte_rdy_o = byte_rdy_q;
  assign frm_err_o  = frm_err_q;

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Serial front end: pairs received bytes into 16-bit commands (high byte first)
// and serialises response bytes onto TX.
module uart_cmd_wrapper
  import la_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 868,
  parameter int unsigned TIMEOUT  = 2000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        tx_busy,
  output logic        frm_err,
  output logic        ovr_err
);

  localparam logic [31:0] TimeoutEnd = 32'(TIMEOUT - 1);
  localparam logic [15:0] BitEnd     = 16'(BAUD_DIV - 1);
  localparam logic [15:0] PreEnd     = 16'(BAUD_DIV - 2);
  localparam logic [3:0]  StopIdx    = 4'(FRAME_BITS - 1);

  logic [7:0] rx_data;
  logic       byte_rdy;

  uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx_i      (RX),
    .data_o    (rx_data),
    .byte_rdy_o(byte_rdy),
    .frm_err_o (frm_err)
  );

  asm_state_e  asm_q;
  logic [15:0] cmd_q;
  logic        cmd_rdy_q, ovr_err_q;
  logic [31:0] timer_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q     <= AsmWaitHi;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
      ovr_err_q <= 1'b0;
      timer_q   <= '0;
    end else begin
      ovr_err_q <= 1'b0;
      unique case (asm_q)
        AsmWaitHi: begin
          timer_q <= '0;
          if (byte_rdy) begin
            cmd_q[OPC_MSB:ADDR_LSB] <= rx_data;
            asm_q                   <= AsmWaitLo;
          end
        end
        AsmWaitLo: begin
          if (byte_rdy) begin
            cmd_q[DATA_MSB:DATA_LSB] <= rx_data;
            cmd_rdy_q                <= 1'b1;
            timer_q                  <= '0;
            asm_q                    <= AsmHold;
          end else if (timer_q == TimeoutEnd) begin
            // Lost low byte: resynchronise, the next byte is a high byte
            timer_q <= '0;
            asm_q   <= AsmWaitHi;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end
        AsmHold: begin
          if (byte_rdy) ovr_err_q <= 1'b1;
          if (clr_cmd_rdy) begin
            cmd_rdy_q <= 1'b0;
            asm_q     <= AsmWaitHi;
          end
        end
        default: asm_q <= AsmWaitHi;
      endcase
    end
  end

  tx_state_e   tx_state_q;
  logic [9:0]  frame_q;
  logic [15:0] tx_cnt_q;
  logic [3:0]  tx_idx_q;
  logic        tx_q, tx_busy_q, resp_sent_q;
  logic        tx_done, tx_accept;

  // Final cycle of the stop bit also accepts a new request back-to-back
  assign tx_done   = (tx_state_q == TxXmit) && (tx_cnt_q == BitEnd) && (tx_idx_q == StopIdx);
  assign tx_accept = send_resp && ((tx_state_q == TxIdle) || tx_done);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q  <= TxIdle;
      frame_q     <= '1;
      tx_cnt_q    <= '0;
      tx_idx_q    <= '0;
      tx_q        <= 1'b1;
      tx_busy_q   <= 1'b0;
      resp_sent_q <= 1'b0;
    end else begin
      resp_sent_q <= 1'b0;
      if (tx_accept) begin
        frame_q    <= {1'b1, resp, 1'b0};
        tx_q       <= 1'b0;
        tx_busy_q  <= 1'b1;
        tx_cnt_q   <= '0;
        tx_idx_q   <= '0;
        tx_state_q <= TxXmit;
      end else if (tx_done) begin
        tx_q       <= 1'b1;
        tx_busy_q  <= 1'b0;
        tx_state_q <= TxIdle;
      end else if (tx_state_q == TxXmit) begin
        if (tx_cnt_q == BitEnd) begin
          tx_cnt_q <= '0;
          tx_idx_q <= tx_idx_q + 4'd1;
          frame_q  <= {1'b1, frame_q[9:1]};
          tx_q     <= frame_q[1];
        end else begin
          tx_cnt_q <= tx_cnt_q + 16'd1;
          if ((tx_idx_q == StopIdx) && (tx_cnt_q == PreEnd)) resp_sent_q <= 1'b1;
        end
      end
    end
  end

  assign TX        = tx_q;
  assign tx_busy   = tx_busy_q;
  assign resp_sent = resp_sent_q;
  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign ovr_err   = ovr_err_q;

endmodule
